// File: rtl/bk_arb_pkg.sv
// Shared types for the shared Brent-Kung adder arbiter: widths, response record, response-slot state.
// Package only: no latency or flow-control behaviour of its own.
package bk_arb_pkg;

  localparam int ADD_W    = 12;
  localparam int SUM_W    = 13;
  localparam int MAX_ID_W = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [SUM_W-1:0]    sum;
  } rsp_t;

endpackage

// File: rtl/BrentKung.sv
// 12-bit Brent-Kung parallel-prefix adder; operand bits interleaved a[k],b[k]; no carry-in.
// Purely combinational, zero latency, no flow control.
module BrentKung
  import bk_arb_pkg::*;
(
  input  logic [2*ADD_W-1:0] INPUTS,
  output logic [SUM_W-1:0]   OUTS
);

  logic [ADD_W-1:0] w_g;
  logic [ADD_W-1:0] w_p;
  logic [ADD_W-1:0] w_gg;
  logic [ADD_W-1:0] w_pp;

  always_comb begin
    w_g = '0;
    w_p = '0;
    for (int k = 0; k < ADD_W; k++) begin
      w_g[k] = INPUTS[2*k] & INPUTS[2*k+1];
      w_p[k] = INPUTS[2*k] ^ INPUTS[2*k+1];
    end
  end

  // Up-sweep builds power-of-two spans, down-sweep fills the remaining prefixes.
  always_comb begin
    w_gg = w_g;
    w_pp = w_p;
    for (int d = 1; d < ADD_W; d = d * 2) begin
      for (int i = 2*d - 1; i < ADD_W; i = i + 2*d) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
    for (int d = 8; d >= 1; d = d / 2) begin
      for (int i = 3*d - 1; i < ADD_W; i = i + 2*d) begin
        w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i-d]);
      end
    end
  end

  always_comb begin
    OUTS        = '0;
    OUTS[0]     = w_p[0];
    for (int k = 1; k < ADD_W; k++) begin
      OUTS[k] = w_p[k] ^ w_gg[k-1];
    end
    OUTS[ADD_W] = w_gg[ADD_W-1];
  end

endmodule

// File: rtl/bk_rr_arbiter.sv
// N-way round-robin pick: first asserted request at or above i_ptr, wrapping; one-hot grant plus index.
// Combinational, zero latency; the caller gates the grant with its own backpressure.
module bk_rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/bk_add_share_arb.sv
// Shares one Brent-Kung adder among N_REQ requesters; round-robin grant, sum registered with winner ID.
// Latency 1 cycle; grants only when the single response slot is empty or draining this cycle.
module bk_add_share_arb
  import bk_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*ADD_W-1:0] req_a,
  input  logic [N_REQ*ADD_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [SUM_W-1:0]       rsp_sum,
  output logic [15:0]            op_count
);

  rsp_state_e        r_state;
  rsp_state_e        w_state_nxt;
  rsp_t              r_rsp;
  logic [ID_W-1:0]   r_ptr;
  logic [15:0]       r_cnt;

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic              w_slot_free;
  logic              w_xfer;
  logic [ADD_W-1:0]  w_a;
  logic [ADD_W-1:0]  w_b;
  logic [2*ADD_W-1:0] w_add_in;
  logic [SUM_W-1:0]  w_sum;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_unused_id;

  bk_rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_slot_free = (r_state == EMPTY) || rsp_ready;
  // Held at zero during reset so nothing is accepted while state is being cleared.
  assign req_ready   = (rst_n && w_slot_free && w_any) ? w_gnt : '0;
  assign w_xfer      = |(req_valid & req_ready);

  assign w_a = req_a[int'(w_idx)*ADD_W +: ADD_W];
  assign w_b = req_b[int'(w_idx)*ADD_W +: ADD_W];

  always_comb begin
    w_add_in = '0;
    for (int k = 0; k < ADD_W; k++) begin
      w_add_in[2*k]   = w_a[k];
      w_add_in[2*k+1] = w_b[k];
    end
  end

  BrentKung u_add (
    .INPUTS (w_add_in),
    .OUTS   (w_sum)
  );

  assign w_ptr_nxt = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_xfer) w_state_nxt = FULL;
      FULL:    if (!w_xfer && rsp_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_rsp.id  <= MAX_ID_W'(w_idx);
      r_rsp.sum <= w_sum;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= r_cnt + 16'd1;
    end
  end

  assign rsp_valid   = (r_state == FULL);
  assign rsp_id      = r_rsp.id[ID_W-1:0];
  assign rsp_sum     = r_rsp.sum;
  assign op_count    = r_cnt;
  assign w_unused_id = ^r_rsp.id;

endmodule

// File: tb/tb_bk_add_share_arb.sv
// Directed bench for bk_add_share_arb: rotation, backpressure, reset, wrap and a long random stream.
module tb_bk_add_share_arb;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*12-1:0] req_a;
  logic [N*12-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [12:0]     rsp_sum;
  logic [15:0]     op_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] ta [N];
  logic [11:0] tb [N];
  logic [12:0] ts [N];
  logic [11:0] ra, rb;
  logic [1:0]  kk;
  logic [12:0] es;

  bk_add_share_arb #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_table;
    for (int i = 0; i < N; i++) begin
      req_a[i*12 +: 12] = ta[i];
      req_b[i*12 +: 12] = tb[i];
    end
  endtask

  initial begin
    ta[0] = 12'h123; tb[0] = 12'h456; ts[0] = 13'h0579;
    ta[1] = 12'h800; tb[1] = 12'h800; ts[1] = 13'h1000;
    ta[2] = 12'hABC; tb[2] = 12'h001; ts[2] = 13'h0ABD;
    ta[3] = 12'hFFF; tb[3] = 12'hFFF; ts[3] = 13'h1FFE;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_sum",   32'(rsp_sum),   32'd0);
    chk("rst_cnt",   32'(op_count),  32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick; tick;
    @(negedge clk); rst_n = 1'b1;

    // Single requester with carry-out.
    req_a[11:0] = 12'hFFF; req_b[11:0] = 12'h001; req_valid = 4'b0001; rsp_ready = 1'b1;
    #1;
    chk("t1_gnt", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_id",    32'(rsp_id),    32'd0);
    chk("t1_sum",   32'(rsp_sum),   32'h1000);
    chk("t1_cnt",   32'(op_count),  32'd1);

    // Pointer now 1: requester 3 alone is granted and the pointer wraps to 0.
    load_table();
    req_valid = 4'b1000;
    #1;
    chk("r3_gnt", 32'(req_ready), 32'h8);
    tick;
    chk("r3_rsp", {rsp_id, rsp_sum}, {2'd3, 13'h1FFE});

    // All requesters valid: grants rotate 0,1,2,3,0.
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rot_gnt", 32'(req_ready), 32'(1 << (k % 4)));
      tick;
      chk("rot_rsp", {rsp_id, rsp_sum}, {2'(k % 4), ts[k % 4]});
    end
    chk("rot_cnt", 32'(op_count), 32'd7);

    // Backpressure while FULL: no grants, response frozen.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_gnt", 32'(req_ready), 32'd0);
      tick;
      chk("bp_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd0, 13'h0579});
    end
    chk("bp_cnt", 32'(op_count), 32'd7);
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_gnt", 32'(req_ready), 32'h2);
    tick;
    chk("bp_rel_rsp", {rsp_id, rsp_sum}, {2'd1, 13'h1000});
    chk("bp_rel_cnt", 32'(op_count), 32'd8);

    // Reset while FULL holding requester 2's result.
    #1;
    chk("pre_rst_gnt", 32'(req_ready), 32'h4);
    tick;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    tick;
    chk("pre_rst_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd2, 13'h0ABD});
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_id",    32'(rsp_id),    32'd0);
    chk("mid_rst_sum",   32'(rsp_sum),   32'd0);
    chk("mid_rst_cnt",   32'(op_count),  32'd0);
    chk("mid_rst_gnt",   32'(req_ready), 32'd0);
    tick;
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("post_rst_gnt", 32'(req_ready), 32'h4);
    tick;
    chk("post_rst_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, 2'd2, 13'h0ABD});
    chk("post_rst_cnt", 32'(op_count), 32'd1);
    req_valid = '0;
    tick;
    chk("drain", {rsp_valid, rsp_id, rsp_sum}, {1'b0, 2'd2, 13'h0ABD});

    // Long random stream from a fresh reset; counter wraps past 65535.
    rst_n = 1'b0;
    tick;
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    for (int n = 0; n < 70000; n++) begin
      kk = 2'($urandom_range(0, 3));
      ra = 12'($urandom);
      rb = 12'($urandom);
      es = {1'b0, ra} + {1'b0, rb};
      req_a = '0; req_b = '0;
      req_a[int'(kk)*12 +: 12] = ra;
      req_b[int'(kk)*12 +: 12] = rb;
      req_valid = 4'(1 << kk);
      tick;
      chk("rnd_rsp", {rsp_valid, rsp_id, rsp_sum}, {1'b1, kk, es});
    end
    req_valid = '0;
    chk("wrap_cnt", 32'(op_count), 32'd4464);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bk_add_share_arb.md
# bk_add_share_arb

Round-robin arbiter and result stage that shares one 12-bit `BrentKung` adder instance among `N_REQ` requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester per cycle and drives that pair through the adder.
- It registers the 13-bit sum with the winner's ID on a single-entry response port.
- It sits between the requesting datapath units and the shared adder, so no requester owns the adder directly.

## Interface
- `N_REQ`, default 4, number of requesters (2..8)
- `ID_W`, default 2, width of requester ID, equals clog2(N_REQ)
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  per-requester operand valid
- `req_ready`  out  N_REQ  per-requester grant/accept, one-hot or zero
- `req_a`  in  N_REQ*12  operand A, requester i at bits [12i+11:12i]
- `req_b`  in  N_REQ*12  operand B, same packing
- `rsp_valid`  out  1  response register holds a result
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  ID_W  index of the requester that produced the response
- `rsp_sum`  out  13  sum, bit 12 = carry-out
- `op_count`  out  16  count of accepted requests, wraps at 65535 -> 0

## Operation
- Adder hookup:
  - `INPUTS[2k]` = a[k] and `INPUTS[2k+1]` = b[k], for k = 0..11.
  - `OUTS[12:0]` = sum.
  - No carry-in.
- Response register states:
  - EMPTY (`rsp_valid`=0).
  - FULL (`rsp_valid`=1).
- Slot free when `!rsp_valid || rsp_ready`.
- Arbitration when slot free:
  - Scan requesters from `rr_ptr` upward, with wrap-around.
  - The first i with `req_valid[i]` wins.
  - `req_ready[i]`=1 for the winner only, combinationally in the same cycle.
- Slot not free: `req_ready` = all zeros.
- Transfer on requester i = `req_valid[i] && req_ready[i]`. At the next edge:
  - the response register loads the adder output for the muxed `req_a[i]`/`req_b[i]`;
  - `rsp_id` = i;
  - `rsp_valid` = 1;
  - `rr_ptr` = (i+1) mod N_REQ;
  - `op_count` increments.
- No transfer but `rsp_ready` with `rsp_valid`: `rsp_valid` -> 0, and `rsp_sum`/`rsp_id` hold their last value.
- FULL with `rsp_ready`=0:
  - `rsp_valid`, `rsp_id` and `rsp_sum` stay stable.
  - No grant is issued.
  - `rr_ptr` and `op_count` unchanged.
- Simultaneous drain and accept in the same cycle: the new result replaces the old one, and `rsp_valid` stays 1 (full throughput).
- No valid requests: `rr_ptr` holds.
- Sum arithmetic: unsigned, `rsp_sum` = a + b, range 0..8190.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until `req_ready`. The arbiter never drops a pending request.
- Fairness: each waiting requester is granted within N_REQ transfers.

## Timing
- Reset (async assert, sync-released externally):
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `op_count`=0.
  - `rr_ptr`=0, `req_ready`=0.
- Reset mid-operation: a pending response is discarded and the ungranted requests are re-arbitrated after release, starting from requester 0.
- Latency: transfer at edge t gives `rsp_valid` visible after edge t, so the response is available in cycle t+1.
- Throughput: 1 result per cycle while `rsp_ready`=1.
- Combinational paths:
  - `req_valid` -> `req_ready`.
  - `rsp_ready` -> `req_ready`.
  - Operand mux -> adder -> response register D input. The full adder path is a single-cycle path.
- No combinational path from `req_*` to `rsp_*`.

## Structure
- Shared package `bk_arb_pkg`:
  - `ADD_W`=12, `SUM_W`=13.
  - Response struct {id, sum}.
  - `rsp_state_e` {EMPTY, FULL}.
- Sub-module `bk_rr_arbiter`: parameterised N-way round-robin grant from `req` vector and `rr_ptr`, producing a one-hot grant and an encoded index.
- The top level holds:
  - the operand mux;
  - the `BrentKung` instance;
  - the response register, `rr_ptr` and `op_count`.

## Test plan
- Reset, then requester 0 only, a=0xFFF, b=0x001, `rsp_ready`=1:
  - grant in cycle 0;
  - next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x1000;
  - `op_count`=1.
- All four `req_valid` high continuously, `rsp_ready`=1:
  - grants rotate 0,1,2,3,0, one per cycle;
  - `rsp_id` sequence follows one cycle later.
- Backpressure: `rsp_ready`=0 for 5 cycles with FULL:
  - `req_ready`=0 throughout;
  - `rsp_sum`/`rsp_id` are constant.
  - On raising `rsp_ready`, the same-cycle grant goes to `rr_ptr`'s next requester.
- Assert `rst_n` low while FULL with `rsp_id`=2:
  - all outputs go to zero immediately;
  - after release, requester 2 still valid is re-granted and yields the correct sum.
- Random operand stream, 70000 transfers: every `rsp_sum` matches a+b; `op_count` wraps to 4464.
- Only requester 3 valid while `rr_ptr`=1: granted in the same cycle, and `rr_ptr` becomes 0.
